// File: rtl/leb128_encoder.sv
// LEB128 (unsigned/signed) byte-stream encoder, one byte per out_valid/out_ready handshake.
// Optional LEB128_PAD_EN adds in_pad_len for fixed-width padded encodings.
module leb128_encoder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
`ifdef LEB128_PAD_EN
  input  logic [3:0]       in_pad_len,
`endif
  output logic [3:0]       out_index
);

  localparam int MAX_BYTES = (WIDTH + 6) / 7;
  localparam logic [3:0] LAST_IDX = 4'(MAX_BYTES - 1);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             signed_q, signed_d;
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] rest_arith, rest_logic, rest;
  logic             nat_last, pad_done, last;
`ifdef LEB128_PAD_EN
  logic [3:0]       pad_q, pad_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
`ifdef LEB128_PAD_EN
      pad_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
`ifdef LEB128_PAD_EN
      pad_q    <= pad_d;
`endif
    end
  end

  // Arithmetic shift kept in its own assignment so the ternary cannot strip its signedness.
  always_comb begin
    rest_arith = $signed(sr_q) >>> 7;
    rest_logic = sr_q >> 7;
    rest       = signed_q ? rest_arith : rest_logic;
    if (signed_q)
      nat_last = ((rest == '0) && !sr_q[6]) || ((rest == '1) && sr_q[6]);
    else
      nat_last = (rest == '0);
`ifdef LEB128_PAD_EN
    pad_done = ({1'b0, idx_q} + 5'd1) >= {1'b0, pad_q};
`else
    pad_done = 1'b1;
`endif
    last = (nat_last && pad_done) || (idx_q == LAST_IDX);
  end

  // Pad groups fall out of continuing the shift: rest is 0 or all-ones past the terminal group.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    signed_d = signed_q;
    idx_d    = idx_q;
`ifdef LEB128_PAD_EN
    pad_d    = pad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d  = S_EMIT;
          sr_d     = in_data;
          signed_d = in_signed;
          idx_d    = '0;
`ifdef LEB128_PAD_EN
          pad_d    = (in_pad_len > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : in_pad_len;
`endif
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            sr_d  = rest;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_EMIT);
    out_last  = out_valid && last;
    out_byte  = out_valid ? {~last, sr_q[6:0]} : 8'h00;
    out_index = idx_q;
  end

endmodule

// File: doc/leb128_encoder.md
Name: leb128_encoder

Overview:
- Encodes one WIDTH-bit integer into a WebAssembly LEB128 byte stream, unsigned or signed.
- Emits one byte per handshake.
- It is the writer counterpart of the CPU's immediate-operand LEB128 decoding path.
- Used by the program loader and test infrastructure to build code streams, and to serialise results popped from the CPU result stack.

Parameters:
- WIDTH, 64, operand width in bits. Legal values are 32 and 64.
- MAX_BYTES, (WIDTH+6)/7, maximum encoded length: 10 for 64, 5 for 32. Derived; do not override.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  value to encode
- in_signed  input  1  1 = SLEB128, 0 = ULEB128; sampled with in_data
- in_valid  input  1  input word valid
- in_ready  output  1  encoder can accept a word
- out_byte  output  8  encoded byte; bit7 = continuation
- out_valid  output  1  out_byte valid
- out_ready  input  1  consumer accepts out_byte
- out_last  output  1  current byte is the final byte of the value
- out_index  output  4  0-based index of the current byte within the value

Behaviour:
- Reset (async, active-high):
  - state = IDLE; in_ready = 1; out_valid = 0; out_last = 0; out_index = 0; out_byte = 0.
  - The internal shift register and the signed flag are cleared.
  - Reset asserted mid-emission discards the value. No further bytes are emitted for it.
- States: IDLE and EMIT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: load the shift register with in_data, latch in_signed, set out_index = 0, go to EMIT.
- EMIT:
  - in_ready = 0, out_valid = 1.
  - The first byte is valid the cycle after acceptance.
  - out_byte = {~out_last, sr[6:0]}.
- Termination, combinational on the current shift register. Let rest = sr shifted right by 7: logical shift for unsigned, arithmetic shift for signed.
  - Unsigned: last = (rest == 0).
  - Signed: last = (rest == 0 & sr[6] == 0) | (rest == all-ones & sr[6] == 1).
  - last is also forced to 1 when out_index == MAX_BYTES-1. This is a safety bound; correct arithmetic never needs it.
- On out_valid & out_ready:
  - If not last: sr <= rest, out_index increments, stay in EMIT.
  - If last: go to IDLE, out_index <= 0.
- Backpressure: while out_valid & ~out_ready, out_byte, out_last and out_index are held stable.
- Throughput: N bytes take N handshake cycles, plus one idle cycle before the next acceptance. in_ready is never high in EMIT.
- Width rules:
  - For WIDTH=32, shifts operate on 32 bits. The final 5th byte carries 4 value bits; its upper bits are zero (unsigned) or sign copies (signed).
  - Encoding is always minimal unless the optional feature below is enabled.

Optional Feature:
- Macro: LEB128_PAD_EN.
- With the macro:
  - Adds input in_pad_len[3:0], sampled on acceptance and clamped to MAX_BYTES.
  - The encoder emits at least in_pad_len bytes.
  - After the value's natural terminal group, extra groups are emitted until index == in_pad_len-1. Extra groups are 0x00 for unsigned or non-negative signed values, and 0x7F for negative signed values.
  - All bytes except the final one have bit7 = 1.
  - This produces the fixed-width padded immediates that wasm permits.
  - in_pad_len of 0 or 1 yields the minimal encoding.
- Without the macro: the port is absent and the encoding is always minimal.

Test Plan:
- Unsigned 0 -> single byte 0x00, out_last=1, out_index=0. in_ready returns high the cycle after the handshake.
- Unsigned 624485 -> 0xE5, 0x8E, 0x26 with out_index 0,1,2; out_last only on 0x26.
- Signed -123456 -> 0xC0, 0xBB, 0x78. Signed -1 -> 0x7F. Signed 64 -> 0xC0, 0x00.
- Unsigned 64'hFFFF_FFFF_FFFF_FFFF -> nine 0xFF then 0x01, 10 bytes. With WIDTH=32, 32'hFFFF_FFFF -> 0xFF x4, 0x0F.
- Backpressure on value 624485: out_ready toggles 1,0,0,1,0,1 -> out_byte/out_index hold stable during stalls; same 3-byte sequence results.
- Reset pulse asserted after the first byte of 624485 -> out_valid drops immediately, in_ready=1. Next value 1 encodes as 0x01.
- With LEB128_PAD_EN:
  - Unsigned 1, pad 3 -> 0x81, 0x80, 0x00.
  - Signed -1, pad 3 -> 0xFF, 0xFF, 0x7F.
